// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - round-robin arbiter, one registered grant, no preemption
// Optional grant timeout compiled in with ROUND_ROBIN_ARBITER_TIMEOUT_EN.
module round_robin_arbiter #(
  parameter int NUMBER_OF_DEVICES = 4,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_DEVICES-1:0] requests,
  output logic [NUMBER_OF_DEVICES-1:0] grants,
  output logic                         busy
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int IDX_W = (NUMBER_OF_DEVICES > 1) ? $clog2(NUMBER_OF_DEVICES) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] pointer, owner, winner, pointer_after;
  logic             any_request, owner_request, release_now, revoke_now;

`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count;
  assign revoke_now = (state == GRANTED) && owner_request && (count == CNT_W'(TIMEOUT_CYCLES));
`else
  assign revoke_now = 1'b0;
`endif

  assign any_request   = |requests;
  assign owner_request = requests[owner];
  assign release_now   = (state == GRANTED) && !owner_request;
  assign pointer_after = (owner == IDX_W'(NUMBER_OF_DEVICES - 1)) ? '0 : owner + 1'b1;

  // First requester at or above the pointer, wrapping past the top index.
  always_comb begin
    int  idx;
    logic found;
    winner = pointer;
    found  = 1'b0;
    for (int k = 0; k < NUMBER_OF_DEVICES; k++) begin
      idx = int'(pointer) + k;
      if (idx >= NUMBER_OF_DEVICES) idx = idx - NUMBER_OF_DEVICES;
      if (!found && requests[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pointer <= '0;
      owner   <= '0;
      grants  <= '0;
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
      count   <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state <= next_state;
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
      timeout <= revoke_now;
`endif
      case (state)
        IDLE: begin
          if (any_request) begin
            owner  <= winner;
            grants <= NUMBER_OF_DEVICES'(1) << winner;
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
            count  <= CNT_W'(1);
`endif
          end
        end
        GRANTED: begin
          if (release_now || revoke_now) begin
            grants  <= '0;
            pointer <= pointer_after;
          end
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
          else begin
            count <= count + 1'b1;
          end
`endif
        end
        default: grants <= '0;
      endcase
    end
  end

  // Leaving GRANTED always passes through IDLE, giving the mandatory turnaround cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_request) next_state = GRANTED;
      GRANTED: if (release_now || revoke_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = |grants;
  end

endmodule
